// File: rtl/ir_code_for_schm.sv
// Instruction register for the 16-bit accumulator datapath.
// Captures the fetched word when the control unit asserts enable (IRWrite),
// holds it during execution, and exposes the opcode plus pre-decoded
// immediate fields. Every output is a plain slice or extension of the
// held word, so outputs move only on a capturing edge or on reset.
module ir_code_for_schm (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] Instruction,
  input  logic        enable,
  output logic [15:0] OutputInst,
  output logic [4:0]  opCode,
  output logic [10:0] immField,
  output logic [15:0] immSext,
  output logic [15:0] immZext,
  output logic        loaded
);

  logic [15:0] r_ir;
  logic        r_loaded;
  logic [10:0] w_imm;

  // Capture the instruction word and the loaded flag on enabled edges;
  // asynchronous reset clears both and takes priority over enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ir     <= '0;
      r_loaded <= 1'b0;
    end else if (enable) begin
      r_ir     <= Instruction;
      r_loaded <= 1'b1;
    end
  end

  assign w_imm      = r_ir[10:0];
  assign OutputInst = r_ir;
  assign opCode     = r_ir[15:11];
  assign immField   = w_imm;
  assign immSext    = {{5{w_imm[10]}}, w_imm};
  assign immZext    = {5'b0, w_imm};
  assign loaded     = r_loaded;

endmodule

// File: tb/tb_ir_code_for_schm.sv
// Self-checking bench for ir_code_for_schm: directed scenarios plus
// randomized traffic compared against an arithmetic reference model.
module tb_ir_code_for_schm;

  logic        CLK;
  logic        RST_N;
  logic [15:0] Instruction;
  logic        enable;
  logic [15:0] OutputInst;
  logic [4:0]  opCode;
  logic [10:0] immField;
  logic [15:0] immSext;
  logic [15:0] immZext;
  logic        loaded;

  int unsigned tests;
  int unsigned fails;

  // Reference model state: the word the IR should hold and the loaded flag.
  logic [15:0] m_ir;
  logic        m_loaded;

  logic [64:0] w_obs;
  assign w_obs = {OutputInst, opCode, immField, immSext, immZext, loaded};

  ir_code_for_schm dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Instruction(Instruction),
    .enable     (enable),
    .OutputInst (OutputInst),
    .opCode     (opCode),
    .immField   (immField),
    .immSext    (immSext),
    .immZext    (immZext),
    .loaded     (loaded)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected output bundle derived arithmetically from a held word.
  function automatic logic [64:0] expv(input logic [15:0] ir, input logic ld);
    logic [31:0] op, imm, sx;
    op  = 32'(ir) / 2048;
    imm = 32'(ir) % 2048;
    sx  = (imm >= 1024) ? imm + 65536 - 2048 : imm;
    return {ir, op[4:0], imm[10:0], sx[15:0], imm[15:0], ld};
  endfunction

  // Drive inputs while CLK is low, then let one rising edge act on them.
  task automatic drive_edge(input logic [15:0] ins, input logic en);
    @(negedge CLK);
    Instruction = ins;
    enable      = en;
    @(posedge CLK);
    if (RST_N && en) begin
      m_ir     = ins;
      m_loaded = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; Instruction = 16'hFFFF; enable = 1'b1;
    m_ir = '0; m_loaded = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (w_obs !== expv(16'h0000, 1'b0)) begin
      fails++;
      $display("FAIL reset: got %h, expected %h", w_obs, expv(16'h0000, 1'b0));
    end
  endtask

  task automatic test_load();
    @(negedge CLK);
    RST_N = 1'b1;
    drive_edge(16'b1011000000001111, 1'b1);
    tests++;
    if (OutputInst !== 16'b1011000000001111 || opCode !== 5'b10110 ||
        immField !== 11'h00F || immSext !== 16'h000F || loaded !== 1'b1) begin
      fails++;
      $display("FAIL load: got inst=%h op=%b imm=%h sext=%h ld=%b, expected inst=b00f op=10110 imm=00f sext=000f ld=1",
               OutputInst, opCode, immField, immSext, loaded);
    end
    tests++;
    if (w_obs !== expv(m_ir, m_loaded)) begin
      fails++;
      $display("FAIL load_model: got %h, expected %h", w_obs, expv(m_ir, m_loaded));
    end
  endtask

  task automatic test_reload();
    @(negedge CLK);
    Instruction = 16'b0011100000111010;
    enable = 1'b1;
    #2;
    tests++;
    if (OutputInst !== 16'b1011000000001111 || opCode !== 5'b10110) begin
      fails++;
      $display("FAIL reload_low_phase: got inst=%h op=%b, expected inst=b00f op=10110", OutputInst, opCode);
    end
    drive_edge(16'b0011100000111010, 1'b1);
    tests++;
    if (OutputInst !== 16'b0011100000111010 || opCode !== 5'b00111) begin
      fails++;
      $display("FAIL reload: got inst=%h op=%b, expected inst=383a op=00111", OutputInst, opCode);
    end
  endtask

  task automatic test_hold();
    drive_edge(16'hFFFF, 1'b0);
    tests++;
    if (OutputInst !== 16'b0011100000111010 || opCode !== 5'b00111 || loaded !== 1'b1) begin
      fails++;
      $display("FAIL hold_ffff: got inst=%h op=%b ld=%b, expected inst=383a op=00111 ld=1", OutputInst, opCode, loaded);
    end
    drive_edge(16'h0000, 1'b0);
    tests++;
    if (OutputInst !== 16'b0011100000111010 || opCode !== 5'b00111 || loaded !== 1'b1) begin
      fails++;
      $display("FAIL hold_0000: got inst=%h op=%b ld=%b, expected inst=383a op=00111 ld=1", OutputInst, opCode, loaded);
    end
  endtask

  task automatic test_sign_ext();
    drive_edge(16'b0000010000000001, 1'b1);
    tests++;
    if (immSext !== 16'hFC01 || immZext !== 16'h0401 || opCode !== 5'b00000 || immField !== 11'h401) begin
      fails++;
      $display("FAIL sign_ext: got sext=%h zext=%h op=%b imm=%h, expected sext=fc01 zext=0401 op=00000 imm=401",
               immSext, immZext, opCode, immField);
    end
    drive_edge(16'hFBFF, 1'b1);
    tests++;
    if (immSext !== 16'h03FF || immZext !== 16'h03FF || opCode !== 5'b11111) begin
      fails++;
      $display("FAIL sign_ext_pos: got sext=%h zext=%h op=%b, expected sext=03ff zext=03ff op=11111",
               immSext, immZext, opCode);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    for (int unsigned i = 0; i < 8; i++) begin
      w = 16'($urandom);
      drive_edge(w, 1'b1);
      tests++;
      if (w_obs !== expv(w, 1'b1)) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %h, expected %h", i, w_obs, expv(w, 1'b1));
      end
    end
  endtask

  task automatic test_async_reset();
    drive_edge(16'hA5C3, 1'b1);
    // CLK is high here; reset must clear outputs without any edge.
    RST_N = 1'b0;
    m_ir = '0; m_loaded = 1'b0;
    #1;
    tests++;
    if (w_obs !== expv(16'h0000, 1'b0) || CLK !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: got %h clk=%b, expected %h clk=1", w_obs, CLK, expv(16'h0000, 1'b0));
    end
    drive_edge(16'h1234, 1'b1);
    tests++;
    if (w_obs !== expv(16'h0000, 1'b0)) begin
      fails++;
      $display("FAIL reset_priority: got %h, expected %h", w_obs, expv(16'h0000, 1'b0));
    end
    @(negedge CLK);
    RST_N = 1'b1;
    drive_edge(16'h1234, 1'b1);
    tests++;
    if (w_obs !== expv(16'h1234, 1'b1)) begin
      fails++;
      $display("FAIL first_load_after_reset: got %h, expected %h", w_obs, expv(16'h1234, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic        en;
    for (int unsigned i = 0; i < 200; i++) begin
      w  = 16'($urandom);
      en = ($urandom_range(0, 2) != 0);
      drive_edge(w, en);
      tests++;
      if (w_obs !== expv(m_ir, m_loaded)) begin
        fails++;
        $display("FAIL random[%0d]: got %h, expected %h", i, w_obs, expv(m_ir, m_loaded));
      end
      // Glitch the input after the edge; outputs must not follow it.
      Instruction = 16'($urandom);
      #2;
      tests++;
      if (w_obs !== expv(m_ir, m_loaded)) begin
        fails++;
        $display("FAIL random_glitch[%0d]: got %h, expected %h", i, w_obs, expv(m_ir, m_loaded));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST_N = 1'b0;
    Instruction = '0;
    enable = 1'b0;
    test_reset();
    test_load();
    test_reload();
    test_hold();
    test_sign_ext();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
